// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: arbiter state encodings and grant IDs
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_BUSY_I = 2'd1, ARB_BUSY_D = 2'd2} arb_state_t;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: 2-way round-robin picker; ports: i_elig, d_elig, last_grant -> grant_valid, grant_id
module arb_rr_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic i_elig,
  input  logic d_elig,
  input  gnt_t last_grant,
  output logic grant_valid,
  output gnt_t grant_id
);
  always_comb begin
    grant_valid = i_elig | d_elig;
    grant_id    = (i_elig & d_elig) ? ((last_grant == GNT_I) ? GNT_D : GNT_I) : (i_elig ? GNT_I : GNT_D);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port between fetch (i_*) and data (d_*) requesters, driving mem_*, with busy/timeout_err/num_access status
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [WORD_SIZE-1:0] num_access
);
  localparam logic                 TO_EN   = TIMEOUT != 0;
  localparam logic [WORD_SIZE-1:0] TO_LAST = WORD_SIZE'(TIMEOUT - 1);
  arb_state_t           state, state_n;
  gnt_t                 last_grant, gid;
  logic                 gv, grant, hit, tmo, fin, we_lat;
  logic [WORD_SIZE-1:0] addr_lat, wdata_lat, wait_cnt;
  arb_rr_pick u_pick (
    .i_elig      (i_req & ~i_done),
    .d_elig      (d_req & ~d_done),
    .last_grant  (last_grant),
    .grant_valid (gv),
    .grant_id    (gid)
  );
  always_comb begin
    busy      = state != ARB_IDLE;
    grant     = ~busy & gv;
    hit       = busy & mem_ready;
    tmo       = busy & ~mem_ready & TO_EN & (wait_cnt == TO_LAST);
    fin       = hit | tmo;
    state_n   = busy ? (fin ? ARB_IDLE : state) : (gv ? ((gid == GNT_I) ? ARB_BUSY_I : ARB_BUSY_D) : ARB_IDLE);
    mem_read  = (state == ARB_BUSY_I) | ((state == ARB_BUSY_D) & ~we_lat);
    mem_write = (state == ARB_BUSY_D) & we_lat;
    mem_addr  = busy ? addr_lat : '0;
    mem_wdata = mem_write ? wdata_lat : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ARB_IDLE;
      last_grant  <= GNT_D;
      addr_lat    <= '0;
      we_lat      <= 1'b0;
      wdata_lat   <= '0;
      wait_cnt    <= '0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      timeout_err <= 1'b0;
      num_access  <= '0;
    end else begin
      state       <= state_n;
      i_done      <= fin & (state == ARB_BUSY_I);
      d_done      <= fin & (state == ARB_BUSY_D);
      i_rdata     <= (hit & (state == ARB_BUSY_I)) ? mem_rdata : '0;
      d_rdata     <= (hit & (state == ARB_BUSY_D) & ~we_lat) ? mem_rdata : '0;
      timeout_err <= timeout_err | tmo;
      num_access  <= num_access + WORD_SIZE'(hit);
      wait_cnt    <= busy ? wait_cnt + 1'b1 : '0;
      if (grant) begin
        last_grant <= gid;
        addr_lat   <= (gid == GNT_I) ? i_addr : d_addr;
        we_lat     <= (gid == GNT_D) & d_we;
        wdata_lat  <= (gid == GNT_D) ? d_wdata : '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences for timeout, wrap and reset corners
module tb_mem_port_arbiter;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, num_access;
  logic        i_done, d_done, mem_read, mem_write, busy, timeout_err;
  int          n_checks = 0, n_fail = 0;
  mem_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .timeout_err(timeout_err), .num_access(num_access)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        ir;
    logic [15:0] ia;
    logic        dr, dw;
    logic [15:0] da, dwd;
    logic        rdy;
    logic [15:0] mrd;
    logic [4:0]  ctl;
    logic [15:0] addr, wd, ird, drd, num;
  } vec_t;
  vec_t v[17];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [4:0] ctl();
    return {mem_read, mem_write, busy, i_done, d_done};
  endfunction
  initial begin
    int cnt;
    logic got;
    //          ir ia       dr dw da       dwd      rdy mrd       ctl       addr     wd       ird      drd      num
    v[0]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 5'b10100, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'd0};
    v[1]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 16'hA5A5, 5'b00010, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000, 16'd1};
    v[2]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd1};
    v[3]  = '{0, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd1};
    v[4]  = '{1, 16'h0030, 1, 0, 16'h0020, 16'h0000, 1, 16'h1111, 5'b10100, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 16'd1};
    v[5]  = '{1, 16'h0030, 1, 0, 16'h0020, 16'h0000, 1, 16'h1111, 5'b00001, 16'h0000, 16'h0000, 16'h0000, 16'h1111, 16'd2};
    v[6]  = '{1, 16'h0030, 1, 0, 16'h0020, 16'h0000, 1, 16'h2222, 5'b10100, 16'h0030, 16'h0000, 16'h0000, 16'h0000, 16'd2};
    v[7]  = '{1, 16'h0030, 1, 0, 16'h0020, 16'h0000, 1, 16'h3333, 5'b00010, 16'h0000, 16'h0000, 16'h3333, 16'h0000, 16'd3};
    v[8]  = '{1, 16'h0030, 1, 0, 16'h0020, 16'h0000, 1, 16'h3333, 5'b10100, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 16'd3};
    v[9]  = '{1, 16'h0030, 1, 0, 16'h0020, 16'h0000, 1, 16'h4444, 5'b00001, 16'h0000, 16'h0000, 16'h0000, 16'h4444, 16'd4};
    v[10] = '{0, 16'h0000, 1, 1, 16'h0040, 16'h1234, 0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd4};
    v[11] = '{0, 16'h0000, 1, 1, 16'h0040, 16'h1234, 0, 16'h0000, 5'b01100, 16'h0040, 16'h1234, 16'h0000, 16'h0000, 16'd4};
    v[12] = '{0, 16'h0000, 0, 0, 16'h0077, 16'h0000, 0, 16'h0000, 5'b01100, 16'h0040, 16'h1234, 16'h0000, 16'h0000, 16'd4};
    v[13] = '{0, 16'h0000, 0, 0, 16'h0077, 16'h0000, 0, 16'h0000, 5'b01100, 16'h0040, 16'h1234, 16'h0000, 16'h0000, 16'd4};
    v[14] = '{0, 16'h0000, 0, 0, 16'h0077, 16'h0000, 0, 16'h0000, 5'b01100, 16'h0040, 16'h1234, 16'h0000, 16'h0000, 16'd4};
    v[15] = '{0, 16'h0000, 0, 0, 16'h0077, 16'h0000, 1, 16'hBEEF, 5'b00001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd5};
    v[16] = '{0, 16'h0000, 0, 0, 16'h0077, 16'h0000, 0, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd5};
    tick();
    tick();
    chk("reset_ctl", 32'(ctl()), 0);
    chk("reset_addr", 32'(mem_addr), 0);
    chk("reset_num", 32'(num_access), 0);
    chk("reset_err", 32'(timeout_err), 0);
    reset_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      i_req = v[k].ir; i_addr = v[k].ia; d_req = v[k].dr; d_we = v[k].dw;
      d_addr = v[k].da; d_wdata = v[k].dwd; mem_ready = v[k].rdy; mem_rdata = v[k].mrd;
      tick();
      chk($sformatf("v%0d_ctl", k), 32'(ctl()), 32'(v[k].ctl));
      chk($sformatf("v%0d_addr", k), 32'(mem_addr), 32'(v[k].addr));
      chk($sformatf("v%0d_wdata", k), 32'(mem_wdata), 32'(v[k].wd));
      chk($sformatf("v%0d_irdata", k), 32'(i_rdata), 32'(v[k].ird));
      chk($sformatf("v%0d_drdata", k), 32'(d_rdata), 32'(v[k].drd));
      chk($sformatf("v%0d_num", k), 32'(num_access), 32'(v[k].num));
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050; mem_ready = 1'b0; mem_rdata = 16'hDEAD;
    cnt = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (mem_read) cnt++;
      if (d_done) got = 1'b1;
    end
    chk("timeout_done", 32'(got), 1);
    chk("timeout_strobe_cycles", 32'(cnt), 8);
    chk("timeout_rdata", 32'(d_rdata), 0);
    chk("timeout_err_set", 32'(timeout_err), 1);
    chk("timeout_num", 32'(num_access), 5);
    d_req = 1'b0; i_req = 1'b1; i_addr = 16'h0060;
    tick();
    chk("post_to_grant", 32'({mem_read, mem_addr}), 32'({1'b1, 16'h0060}));
    mem_ready = 1'b1; mem_rdata = 16'h0F0F;
    tick();
    chk("post_to_done", 32'({i_done, i_rdata}), 32'({1'b1, 16'h0F0F}));
    chk("post_to_num", 32'(num_access), 6);
    chk("err_sticky", 32'(timeout_err), 1);
    i_req = 1'b0; mem_ready = 1'b0;
    tick();
    force dut.num_access = 16'hFFFF;
    #1;
    release dut.num_access;
    chk("wrap_preload", 32'(num_access), 32'hFFFF);
    i_req = 1'b1; i_addr = 16'h0090;
    tick();
    mem_ready = 1'b1;
    tick();
    chk("wrap_done", 32'(i_done), 1);
    chk("wrap_num", 32'(num_access), 0);
    i_req = 1'b0; mem_ready = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0070;
    tick();
    chk("rst_mid_busy", 32'(ctl()), 32'(5'b10100));
    reset_n = 1'b0;
    tick();
    chk("rst_mid_ctl", 32'(ctl()), 0);
    chk("rst_mid_addr", 32'(mem_addr), 0);
    chk("rst_mid_num", 32'(num_access), 0);
    chk("rst_mid_err", 32'(timeout_err), 0);
    i_req = 1'b1; i_addr = 16'h0080;
    tick();
    chk("rst_hold_ctl", 32'(ctl()), 0);
    reset_n = 1'b1;
    tick();
    chk("rst_tie_to_i", 32'({ctl(), mem_addr}), 32'({5'b10100, 16'h0080}));
    tick();
    chk("rst_no_done", 32'({i_done, d_done}), 0);
    i_req = 1'b0; d_req = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
